// File: rtl/simple_fsm_rle.sv
// Run-length encoder for the simple_fsm sample stream: folds equal consecutive
// samples into (value, length) records and queues them behind valid/ready.
module simple_fsm_rle #(
   parameter int unsigned DataWidth = 16,
   parameter int unsigned LenWidth  = 8,
   parameter int unsigned FifoDepth = 4
) (
   input  logic                           clk_i,
   input  logic                           rst_ni,
   input  logic [DataWidth-1:0]           data_i,
   input  logic                           valid_i,
   input  logic                           flush_i,
   output logic [DataWidth-1:0]           run_value_o,
   output logic [LenWidth-1:0]            run_len_o,
   output logic                           valid_o,
   input  logic                           ready_i,
   output logic [$clog2(FifoDepth+1)-1:0] fill_o,
   output logic                           overflow_o
);

   localparam int unsigned PtrW = (FifoDepth > 1) ? $clog2(FifoDepth) : 1;
   localparam int unsigned CntW = $clog2(FifoDepth + 1);
   localparam logic [LenWidth-1:0] MaxLen  = '1;
   localparam logic [LenWidth-1:0] OneLen  = LenWidth'(1);
   localparam logic [CntW-1:0]     FullCnt = CntW'(FifoDepth);

   // open run and deferred flush
   logic [DataWidth-1:0] cur_val, cur_val_nxt;
   logic [LenWidth-1:0]  cur_len, cur_len_nxt;
   logic                 active, active_nxt;
   logic                 flush_pend, flush_pend_nxt;

   // record queue
   logic [DataWidth-1:0] mem_val [FifoDepth];
   logic [LenWidth-1:0]  mem_len [FifoDepth];
   logic [PtrW-1:0]      wr_ptr, rd_ptr;
   logic [CntW-1:0]      count, count_nxt;

   logic                 push_c, push_ok_c, pop_c, full_c, drop_c;
   logic [DataWidth-1:0] push_val_c;
   logic [LenWidth-1:0]  push_len_c;

   // run tracking: decides what (if anything) is pushed this cycle
   always_comb begin
      push_c         = 1'b0;
      push_val_c     = cur_val;
      push_len_c     = cur_len;
      cur_val_nxt    = cur_val;
      cur_len_nxt    = cur_len;
      active_nxt     = active;
      flush_pend_nxt = flush_pend;
      if (valid_i) begin
         if (flush_i) flush_pend_nxt = 1'b1;
         if (!active) begin
            cur_val_nxt = data_i;
            cur_len_nxt = OneLen;
            active_nxt  = 1'b1;
         end else if (data_i == cur_val && cur_len != MaxLen) begin
            cur_len_nxt = cur_len + OneLen;
         end else begin
            push_c      = 1'b1;
            cur_val_nxt = data_i;
            cur_len_nxt = OneLen;
         end
      end else if (flush_i || flush_pend) begin
         push_c         = active;
         active_nxt     = 1'b0;
         flush_pend_nxt = 1'b0;
      end
   end

   // queue bookkeeping; a pop frees the slot a same-cycle push needs
   always_comb begin
      pop_c     = valid_o & ready_i;
      full_c    = (count == FullCnt);
      push_ok_c = push_c & (~full_c | pop_c);
      drop_c    = push_c & full_c & ~pop_c;
      count_nxt = count;
      unique case ({push_ok_c, pop_c})
         2'b10:   count_nxt = count + CntW'(1);
         2'b01:   count_nxt = count - CntW'(1);
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cur_val    <= '0;
         cur_len    <= '0;
         active     <= 1'b0;
         flush_pend <= 1'b0;
      end else begin
         cur_val    <= cur_val_nxt;
         cur_len    <= cur_len_nxt;
         active     <= active_nxt;
         flush_pend <= flush_pend_nxt;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < int'(FifoDepth); i++) begin
            mem_val[i] <= '0;
            mem_len[i] <= '0;
         end
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         valid_o    <= 1'b0;
         overflow_o <= 1'b0;
      end else begin
         if (push_ok_c) begin
            mem_val[wr_ptr] <= push_val_c;
            mem_len[wr_ptr] <= push_len_c;
            wr_ptr          <= wr_ptr + PtrW'(1);
         end
         if (pop_c) rd_ptr <= rd_ptr + PtrW'(1);
         count   <= count_nxt;
         valid_o <= (count_nxt != '0);
         if (drop_c) overflow_o <= 1'b1;
      end
   end

   assign run_value_o = mem_val[rd_ptr];
   assign run_len_o   = mem_len[rd_ptr];
   assign fill_o      = count;

endmodule

// File: tb/tb_simple_fsm_rle.sv
// Self-checking bench for simple_fsm_rle: directed scenarios plus a randomized
// run against a queue-based reference model.
module tb_simple_fsm_rle;

   localparam int Depth  = 4;
   localparam int MaxLen = 255;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b1;
   logic [15:0] data_i = '0;
   logic        valid_i = 1'b0;
   logic        flush_i = 1'b0;
   logic        ready_i = 1'b0;
   logic [15:0] run_value_o;
   logic [7:0]  run_len_o;
   logic        valid_o;
   logic [2:0]  fill_o;
   logic        overflow_o;

   int tests_run = 0;
   int failures  = 0;

   // reference model state
   int m_val, m_len;
   bit m_act, m_pend, m_ovf;
   int q_val[$];
   int q_len[$];

   simple_fsm_rle dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .valid_i(valid_i),
      .flush_i(flush_i), .run_value_o(run_value_o), .run_len_o(run_len_o),
      .valid_o(valid_o), .ready_i(ready_i), .fill_o(fill_o),
      .overflow_o(overflow_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic model_clear();
      m_val = 0; m_len = 0; m_act = 0; m_pend = 0; m_ovf = 0;
      q_val.delete();
      q_len.delete();
   endtask

   // one clock of stimulus; the model consumes the same inputs at the edge
   task automatic step(input bit v, input int d, input bit f, input bit r);
      bit push;
      int pv, pl;
      valid_i = v; data_i = 16'(d); flush_i = f; ready_i = r;
      @(posedge clk_i);
      push = 0; pv = 0; pl = 0;
      if (q_val.size() != 0 && r) begin
         void'(q_val.pop_front());
         void'(q_len.pop_front());
      end
      if (v) begin
         if (f) m_pend = 1;
         if (!m_act) begin
            m_val = d; m_len = 1; m_act = 1;
         end else if (d == m_val && m_len < MaxLen) begin
            m_len++;
         end else begin
            push = 1; pv = m_val; pl = m_len;
            m_val = d; m_len = 1;
         end
      end else if (f || m_pend) begin
         if (m_act) begin push = 1; pv = m_val; pl = m_len; end
         m_act = 0; m_pend = 0;
      end
      if (push) begin
         if (q_val.size() < Depth) begin
            q_val.push_back(pv);
            q_len.push_back(pl);
         end else m_ovf = 1;
      end
      #1;
   endtask

   task automatic do_reset();
      valid_i = 0; flush_i = 0; ready_i = 0; data_i = '0;
      @(negedge clk_i);
      rst_ni = 0;
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1;
      model_clear();
   endtask

   task automatic test_reset();
      rst_ni = 1;
      #3 rst_ni = 0;
      #1;
      tests_run++; if (valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", valid_o); end
      tests_run++; if (run_value_o !== 16'h0) begin failures++; $display("FAIL reset_value: got %h expected 0000", run_value_o); end
      tests_run++; if (run_len_o !== 8'h0) begin failures++; $display("FAIL reset_len: got %0d expected 0", run_len_o); end
      tests_run++; if (fill_o !== 3'd0) begin failures++; $display("FAIL reset_fill: got %0d expected 0", fill_o); end
      tests_run++; if (overflow_o !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b expected 0", overflow_o); end
      repeat (2) @(posedge clk_i);
      @(negedge clk_i);
      rst_ni = 1;
      model_clear();
   endtask

   task automatic test_basic();
      do_reset();
      for (int i = 0; i < 5; i++) step(1, 16'h00AA, 0, 1);
      tests_run++; if (valid_o !== 1'b0) begin failures++; $display("FAIL basic_no_early: got %b expected 0", valid_o); end
      step(1, 16'h0055, 0, 1);
      tests_run++; if (valid_o !== 1'b1 || run_value_o !== 16'h00AA || run_len_o !== 8'd5)
         begin failures++; $display("FAIL basic_first: got v=%b %h/%0d expected 1 00aa/5", valid_o, run_value_o, run_len_o); end
      step(0, 0, 1, 1);
      tests_run++; if (valid_o !== 1'b1 || run_value_o !== 16'h0055 || run_len_o !== 8'd1 || fill_o !== 3'd1)
         begin failures++; $display("FAIL basic_flush: got v=%b %h/%0d fill=%0d expected 1 0055/1 fill=1", valid_o, run_value_o, run_len_o, fill_o); end
      step(0, 0, 0, 1);
      tests_run++; if (valid_o !== 1'b0 || fill_o !== 3'd0) begin failures++; $display("FAIL basic_drain: got v=%b fill=%0d expected 0/0", valid_o, fill_o); end
   endtask

   task automatic test_maxlen();
      do_reset();
      for (int i = 0; i < 300; i++) step(1, 16'h1234, 0, 0);
      tests_run++; if (fill_o !== 3'd1 || run_len_o !== 8'd255) begin failures++; $display("FAIL maxlen_split: got fill=%0d len=%0d expected 1/255", fill_o, run_len_o); end
      step(0, 0, 1, 0);
      tests_run++; if (fill_o !== 3'd2 || run_value_o !== 16'h1234 || run_len_o !== 8'd255)
         begin failures++; $display("FAIL maxlen_head: got fill=%0d %h/%0d expected 2 1234/255", fill_o, run_value_o, run_len_o); end
      step(0, 0, 0, 1);
      tests_run++; if (valid_o !== 1'b1 || run_value_o !== 16'h1234 || run_len_o !== 8'd45)
         begin failures++; $display("FAIL maxlen_tail: got v=%b %h/%0d expected 1 1234/45", valid_o, run_value_o, run_len_o); end
      step(0, 0, 0, 1);
      tests_run++; if (valid_o !== 1'b0 || overflow_o !== 1'b0) begin failures++; $display("FAIL maxlen_end: got v=%b ovf=%b expected 0/0", valid_o, overflow_o); end
   endtask

   task automatic test_pending_flush();
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 16'h0F0F, 0, 1);
      step(1, 16'h0F0F, 1, 1);
      tests_run++; if (valid_o !== 1'b0) begin failures++; $display("FAIL pend_early: got %b expected 0", valid_o); end
      step(0, 0, 0, 1);
      tests_run++; if (valid_o !== 1'b1 || run_value_o !== 16'h0F0F || run_len_o !== 8'd4)
         begin failures++; $display("FAIL pend_record: got v=%b %h/%0d expected 1 0f0f/4", valid_o, run_value_o, run_len_o); end
      // two flush pulses while pending collapse into one record
      step(1, 16'h0A0A, 1, 1);
      step(1, 16'h0A0A, 1, 1);
      step(0, 0, 0, 1);
      tests_run++; if (valid_o !== 1'b1 || run_value_o !== 16'h0A0A || run_len_o !== 8'd2 || fill_o !== 3'd1)
         begin failures++; $display("FAIL pend_merge: got v=%b %h/%0d fill=%0d expected 1 0a0a/2 fill=1", valid_o, run_value_o, run_len_o, fill_o); end
      step(0, 0, 0, 1);
      step(0, 0, 0, 1);
      tests_run++; if (valid_o !== 1'b0 || fill_o !== 3'd0) begin failures++; $display("FAIL pend_single: got v=%b fill=%0d expected 0/0", valid_o, fill_o); end
   endtask

   task automatic test_overflow();
      int exp_v[4] = '{1, 2, 1, 2};
      do_reset();
      for (int i = 0; i < 6; i++) step(1, (i % 2) + 1, 0, 0);
      tests_run++; if (fill_o !== 3'd4 || overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_full: got fill=%0d ovf=%b expected 4/1", fill_o, overflow_o); end
      for (int i = 0; i < 4; i++) begin
         tests_run++;
         if (valid_o !== 1'b1 || run_value_o !== 16'(exp_v[i]) || run_len_o !== 8'd1)
            begin failures++; $display("FAIL ovf_drain%0d: got v=%b %h/%0d expected 1 %h/1", i, valid_o, run_value_o, run_len_o, exp_v[i]); end
         step(0, 0, 0, 1);
      end
      tests_run++; if (valid_o !== 1'b0 || overflow_o !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got v=%b ovf=%b expected 0/1", valid_o, overflow_o); end
   endtask

   task automatic test_full_pop();
      do_reset();
      for (int i = 1; i <= 5; i++) step(1, i, 0, 0);
      tests_run++; if (fill_o !== 3'd4 || overflow_o !== 1'b0) begin failures++; $display("FAIL fullpop_pre: got fill=%0d ovf=%b expected 4/0", fill_o, overflow_o); end
      step(1, 6, 0, 1);
      tests_run++; if (fill_o !== 3'd4 || overflow_o !== 1'b0) begin failures++; $display("FAIL fullpop_same: got fill=%0d ovf=%b expected 4/0", fill_o, overflow_o); end
      for (int i = 2; i <= 5; i++) begin
         tests_run++;
         if (valid_o !== 1'b1 || run_value_o !== 16'(i) || run_len_o !== 8'd1)
            begin failures++; $display("FAIL fullpop_order%0d: got v=%b %h/%0d expected 1 %h/1", i, valid_o, run_value_o, run_len_o, i); end
         step(0, 0, 0, 1);
      end
      tests_run++; if (valid_o !== 1'b0) begin failures++; $display("FAIL fullpop_empty: got %b expected 0", valid_o); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      for (int i = 0; i < 3; i++) step(1, 16'h00FF, 0, 0);
      step(1, 16'h0001, 0, 0);
      for (int i = 0; i < 4; i++) step(1, 16'h00FF, 0, 0);
      tests_run++; if (fill_o !== 3'd2) begin failures++; $display("FAIL rmid_pre: got fill=%0d expected 2", fill_o); end
      rst_ni = 0;
      #1;
      tests_run++; if (valid_o !== 1'b0 || run_value_o !== 16'h0 || run_len_o !== 8'h0 || fill_o !== 3'd0 || overflow_o !== 1'b0)
         begin failures++; $display("FAIL rmid_async: got v=%b %h/%0d fill=%0d ovf=%b expected all 0", valid_o, run_value_o, run_len_o, fill_o, overflow_o); end
      model_clear();
      @(negedge clk_i);
      rst_ni = 1;
      step(1, 16'h00FF, 0, 0);
      step(1, 16'h00FF, 0, 0);
      step(0, 0, 1, 0);
      tests_run++; if (fill_o !== 3'd1 || run_value_o !== 16'h00FF || run_len_o !== 8'd2)
         begin failures++; $display("FAIL rmid_after: got fill=%0d %h/%0d expected 1 00ff/2", fill_o, run_value_o, run_len_o); end
      step(0, 0, 0, 1);
      tests_run++; if (valid_o !== 1'b0) begin failures++; $display("FAIL rmid_only: got %b expected 0", valid_o); end
   endtask

   task automatic test_random();
      int d, prev;
      bit v, f, r;
      do_reset();
      prev = 1;
      for (int c = 0; c < 600; c++) begin
         v = ($urandom % 4) != 0;
         f = ($urandom % 12) == 0;
         r = ($urandom % 3) != 0;
         d = (($urandom % 3) == 0) ? int'($urandom % 3) + 1 : prev;
         prev = d;
         step(v, d, f, r);
         tests_run++;
         if (valid_o !== (q_val.size() != 0) || fill_o !== 3'(q_val.size()) || overflow_o !== m_ovf)
            begin failures++; $display("FAIL rand_status c=%0d: got v=%b fill=%0d ovf=%b expected %b/%0d/%b", c, valid_o, fill_o, overflow_o, q_val.size() != 0, q_val.size(), m_ovf); end
         if (q_val.size() != 0) begin
            tests_run++;
            if (run_value_o !== 16'(q_val[0]) || run_len_o !== 8'(q_len[0]))
               begin failures++; $display("FAIL rand_head c=%0d: got %h/%0d expected %h/%0d", c, run_value_o, run_len_o, q_val[0], q_len[0]); end
         end
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_basic();
      test_maxlen();
      test_pending_flush();
      test_overflow();
      test_full_pop();
      test_reset_mid();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests_run, failures);
      $finish;
   end

endmodule

// File: doc/simple_fsm_rle.md
SIMPLE_FSM_RLE -- requirements
Module: simple_fsm_rle

Purpose: downstream stage of simple_fsm. Run-length-encodes its 16-bit output stream into (value, length) records and buffers them behind a valid/ready output.

Interface
REQ-001 The block SHALL have parameter DataWidth, default 16, giving the width of the sample and record value.
REQ-002 The block SHALL have parameter LenWidth, default 8, giving the run-length width; max run MaxLen = 2^LenWidth-1.
REQ-003 The block SHALL have parameter FifoDepth, default 4, giving the number of record slots (power of two, >=2).
REQ-004 clk_i  input  1  single clock; all state SHALL update on its rising edge.
REQ-005 rst_ni  input  1  asynchronous active-low reset.
REQ-006 data_i  input  DataWidth  sample, connected to simple_fsm out_o.
REQ-007 valid_i  input  1  data_i is valid this cycle; there is no upstream backpressure.
REQ-008 flush_i  input  1  request to close the open run.
REQ-009 run_value_o  output  DataWidth  value of the head record.
REQ-010 run_len_o  output  LenWidth  length of the head record (1..MaxLen).
REQ-011 valid_o  output  1  head record present (FIFO not empty).
REQ-012 ready_i  input  1  consumer accepts the head record.
REQ-013 fill_o  output  $clog2(FifoDepth+1)  number of stored records.
REQ-014 overflow_o  output  1  sticky flag: at least one record was dropped.

Function
REQ-015 Run register (cur_val, cur_len, active) SHALL update only on cycles with valid_i=1, except for flushes.
REQ-016 valid_i=1, active=0: the block SHALL start a run with cur_val=data_i, cur_len=1, and active=1, without pushing a record.
REQ-017 valid_i=1, active=1, data_i==cur_val, cur_len<MaxLen: the block SHALL increment cur_len.
REQ-018 valid_i=1, active=1, data_i!=cur_val OR cur_len==MaxLen: the block SHALL push (cur_val,cur_len) and start a new run with data_i, length 1.
REQ-019 valid_i=0 cycles SHALL NOT terminate or alter a run.
REQ-020 flush_i=1 with valid_i=0 SHALL push (cur_val,cur_len) if active and clear active; with active=0 it SHALL do nothing.
REQ-021 flush_i=1 with valid_i=1 SHALL set a pending-flush flag; the flush SHALL execute on the first subsequent cycle with valid_i=0, and further flush_i pulses while pending SHALL merge into it.
REQ-022 At most one push SHALL occur per cycle.
REQ-023 A pushed record SHALL appear on valid_o/run_value_o/run_len_o the cycle after the pushing edge when the FIFO was empty (one-cycle latency).
REQ-024 A pop SHALL occur on a rising edge where valid_o=1 and ready_i=1; records SHALL leave in push order.
REQ-025 run_value_o and run_len_o SHALL be driven from FIFO storage and SHALL remain stable while valid_o=1 and ready_i=0.
REQ-026 Push with FIFO full and no pop in the same cycle: the record SHALL be dropped, overflow_o set, and the new run still started.
REQ-027 Push and pop in the same cycle with FIFO full: the push SHALL be accepted, fill_o SHALL be unchanged, and no overflow SHALL occur.
REQ-028 Push and pop in the same cycle otherwise: fill_o SHALL be unchanged.
REQ-029 FIFO read/write pointers SHALL wrap modulo FifoDepth.
REQ-030 fill_o SHALL never exceed FifoDepth nor underflow.
REQ-031 overflow_o SHALL remain 1 until reset.

Reset
REQ-032 While rst_ni=0: valid_o=0, run_value_o=0, run_len_o=0, fill_o=0, overflow_o=0; active, cur_len, cur_val, the pending-flush flag and both pointers SHALL be 0.
REQ-033 Reset assertion mid-run SHALL discard the open run and all stored records, with no record emitted.
REQ-034 The first valid_i=1 after reset release SHALL start a new run per REQ-016.

Verification
REQ-035 ready_i=1; 5 cycles data_i=0x00AA, then 0x0055 (valid_i=1) -> valid_o=1 one cycle later with (0x00AA,5); then flush -> (0x0055,1).
REQ-036 300 consecutive 0x1234, then flush_i with valid_i=0 -> records (0x1234,255) then (0x1234,45), overflow_o=0.
REQ-037 ready_i=0; inputs 0x0001,0x0002,0x0001,0x0002,0x0001,0x0002 -> fill_o=4, overflow_o=1 (5th record dropped); then ready_i=1 drains (1,1),(2,1),(1,1),(2,1) in order.
REQ-038 FIFO full, ready_i=1 and a run-closing input on the same edge -> fill_o stays 4, overflow_o stays 0, order preserved.
REQ-039 3x 0x0F0F, then flush_i=1 with valid_i=1 data_i=0x0F0F, then valid_i=0 -> single record (0x0F0F,4) emitted after the valid_i=0 cycle.
REQ-040 rst_ni pulsed low after 7x 0x00FF with 2 records stored -> all outputs 0 immediately; after release, 2x 0x00FF then flush -> only (0x00FF,2).
